// File: rtl/usb2_ep_arb_if.sv
// -----------------------------------------------------------------------------
// usb2_ep_arb_if
// Endpoint IN-buffer write/commit bus between usb2_ep_arb and a usb2_ep.
//   buf_in_addr/data/wren : buffer write port (arbiter -> endpoint)
//   buf_in_ready          : endpoint current buffer is free (endpoint -> arbiter)
//   buf_in_commit/_len    : commit request and length (arbiter -> endpoint)
//   buf_in_commit_ack     : commit acknowledge, multi-cycle (endpoint -> arbiter)
// -----------------------------------------------------------------------------
interface usb2_ep_arb_if;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_ready;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic       buf_in_commit_ack;

    modport master (
        output buf_in_addr, buf_in_data, buf_in_wren,
        output buf_in_commit, buf_in_commit_len,
        input  buf_in_ready, buf_in_commit_ack
    );

    modport slave (
        input  buf_in_addr, buf_in_data, buf_in_wren,
        input  buf_in_commit, buf_in_commit_len,
        output buf_in_ready, buf_in_commit_ack
    );
endinterface

// File: rtl/usb2_ep_arb.sv
// -----------------------------------------------------------------------------
// usb2_ep_arb
// Round-robin arbiter + commit sequencer sharing one usb2 endpoint IN buffer
// among four producers. The granted producer's write stream is muxed onto the
// endpoint; on req_done the commit handshake is run and a completion (or
// timeout error) pulse is returned.
// Ports:
//   i_phy_clk, i_reset_n : clock, synchronous active-low reset
//   i_req, i_req_done    : per-requester request level / commit-now
//   i_req_len/addr/data  : packed per-requester length(10)/address(9)/data(8)
//   i_req_wren           : per-requester write enable
//   o_gnt                : one-hot registered grant
//   o_commit_done        : one-cycle completion pulse to the granted requester
//   o_commit_err         : one-cycle commit timeout pulse
//   bus                  : endpoint buffer interface (master side)
// -----------------------------------------------------------------------------
module usb2_ep_arb #(
    parameter int         N_REQ       = 4,
    parameter logic [7:0] ACK_TIMEOUT = 8'd255,
    parameter logic [9:0] MAX_LEN     = 10'd512
) (
    input  logic                  i_phy_clk,
    input  logic                  i_reset_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_req_done,
    input  logic [10*N_REQ-1:0]   i_req_len,
    input  logic [9*N_REQ-1:0]    i_req_addr,
    input  logic [8*N_REQ-1:0]    i_req_data,
    input  logic [N_REQ-1:0]      i_req_wren,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_commit_done,
    output logic                  o_commit_err,
    usb2_ep_arb_if.master         bus
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT, S_ACKLOW} state_t;

    state_t            r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [1:0]        r_gidx, w_gidx_nxt;
    logic [1:0]        r_last, w_last_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_commit, w_commit_nxt;
    logic [9:0]        r_len, w_len_nxt;
    logic [N_REQ-1:0]  r_done, w_done_nxt;
    logic              r_err, w_err_nxt;

    logic              w_pick_vld;
    logic [1:0]        w_pick;
    logic [9:0]        w_len_g;

    // Circular search starting just after the last served requester, so the
    // one just served has lowest priority.
    always_comb begin
        logic [1:0] idx;
        w_pick_vld = 1'b0;
        w_pick     = r_last;
        idx        = r_last;
        for (int j = 1; j <= 4; j++) begin
            idx = r_last + 2'(j);
            if (!w_pick_vld && i_req[idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = idx;
            end
        end
    end

    // Write-port mux; wren only passes through while the grant is in FILL.
    assign w_len_g          = i_req_len[10*r_gidx +: 10];
    assign bus.buf_in_addr  = i_req_addr[9*r_gidx +: 9];
    assign bus.buf_in_data  = i_req_data[8*r_gidx +: 8];
    assign bus.buf_in_wren  = (r_state == S_FILL) && i_req_wren[r_gidx];

    assign bus.buf_in_commit     = r_commit;
    assign bus.buf_in_commit_len = r_len;
    assign o_gnt                 = r_gnt;
    assign o_commit_done         = r_done;
    assign o_commit_err          = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gidx_nxt   = r_gidx;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_commit_nxt = r_commit;
        w_len_nxt    = r_len;
        w_done_nxt   = '0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.buf_in_ready && w_pick_vld) begin
                    w_gnt_nxt   = N_REQ'(1) << w_pick;
                    w_gidx_nxt  = w_pick;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (i_req_done[r_gidx]) begin
                    w_len_nxt    = (w_len_g > MAX_LEN) ? MAX_LEN : w_len_g;
                    w_commit_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_COMMIT;
                end else if (!i_req[r_gidx]) begin
                    // Abandoned fill: no commit, and priority is not rotated.
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (bus.buf_in_commit_ack) begin
                    w_commit_nxt = 1'b0;
                    w_state_nxt  = S_ACKLOW;
                end else if (r_cnt == ACK_TIMEOUT - 8'd1) begin
                    // Commit was held for ACK_TIMEOUT cycles with no ack.
                    w_commit_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                    w_gnt_nxt    = '0;
                    w_last_nxt   = r_gidx;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_ACKLOW: begin
                // Ack falling means the endpoint has swapped buffers.
                if (!bus.buf_in_commit_ack) begin
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gidx;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_phy_clk) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gidx   <= '0;
            r_last   <= 2'd3;
            r_cnt    <= '0;
            r_commit <= 1'b0;
            r_len    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gidx   <= w_gidx_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_commit <= w_commit_nxt;
            r_len    <= w_len_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_usb2_ep_arb.sv
// -----------------------------------------------------------------------------
// tb_usb2_ep_arb
// Directed bench for usb2_ep_arb: single transfer, round-robin order, length
// clamp / ZLP, not-ready hold, abort, ack timeout and reset mid-commit.
// -----------------------------------------------------------------------------
module tb_usb2_ep_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req_done, req_wren;
    logic [39:0] req_len;
    logic [35:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  gnt, commit_done;
    logic        commit_err;

    int n_chk = 0;
    int n_err = 0;
    int wren_cnt = 0;

    usb2_ep_arb_if bif ();

    usb2_ep_arb dut (
        .i_phy_clk     (clk),
        .i_reset_n     (rst_n),
        .i_req         (req),
        .i_req_done    (req_done),
        .i_req_len     (req_len),
        .i_req_addr    (req_addr),
        .i_req_data    (req_data),
        .i_req_wren    (req_wren),
        .o_gnt         (gnt),
        .o_commit_done (commit_done),
        .o_commit_err  (commit_err),
        .bus           (bif.master)
    );

    always #5 clk = ~clk;

    // Count write strobes seen by the endpoint, sampled mid-cycle.
    always @(negedge clk) if (bif.buf_in_wren === 1'b1) wren_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Run a commit for the granted requester g and check the handshake.
    task automatic serve(input int g, input logic [9:0] len, input logic [9:0] exp_len);
        req_done[g] = 1'b1;
        req_len[10*g +: 10] = len;
        step();
        req_done[g] = 1'b0;
        chk("commit_rise", 32'(bif.buf_in_commit), 32'd1);
        chk("commit_len", 32'(bif.buf_in_commit_len), 32'(exp_len));
        step(); step(); step();
        chk("commit_hold", 32'(bif.buf_in_commit), 32'd1);
        bif.buf_in_commit_ack = 1'b1;
        step();
        chk("commit_drop", 32'(bif.buf_in_commit), 32'd0);
        chk("done_early", 32'(commit_done), 32'd0);
        step();
        bif.buf_in_commit_ack = 1'b0;
        step();
        chk("done_pulse", 32'(commit_done), 32'(4'b0001 << g));
        chk("gnt_clear", 32'(gnt), 32'd0);
        chk("no_err", 32'(commit_err), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_g;
        int         rr_order [5];
        rr_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; req = '0; req_done = '0; req_wren = '0;
        req_len = '0; req_addr = '0; req_data = '0;
        bif.buf_in_ready = 1'b1; bif.buf_in_commit_ack = 1'b0;
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_commit", 32'(bif.buf_in_commit), 32'd0);
        chk("rst_len", 32'(bif.buf_in_commit_len), 32'd0);
        chk("rst_done", 32'(commit_done), 32'd0);
        chk("rst_err", 32'(commit_err), 32'd0);
        rst_n = 1'b1;

        // Single transfer on requester 0.
        wren_cnt = 0;
        req = 4'b0001;
        step();
        chk("s_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            req_wren[0] = 1'b1;
            req_addr[8:0] = 9'(i);
            req_data[7:0] = 8'hA0 + 8'(i);
            #1;
            chk("s_addr", 32'(bif.buf_in_addr), 32'(i));
            chk("s_data", 32'(bif.buf_in_data), 32'hA0 + 32'(i));
            step();
        end
        req_wren[0] = 1'b0;
        // Non-granted requester strobes must be ignored.
        req_wren[1] = 1'b1; req_done[1] = 1'b1;
        #1;
        chk("ign_wren", 32'(bif.buf_in_wren), 32'd0);
        step();
        chk("ign_done", 32'(bif.buf_in_commit), 32'd0);
        req_wren[1] = 1'b0; req_done[1] = 1'b0;
        serve(0, 10'd3, 10'd3);
        req = 4'b0000;
        step();
        chk("s_done_1cyc", 32'(commit_done), 32'd0);
        chk("s_wren_cnt", 32'(wren_cnt), 32'd3);

        // Round-robin with all requesting.
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << rr_order[k];
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            serve(rr_order[k], 10'd8, 10'd8);
            step();
        end

        // Length clamp then zero-length packet.
        do_reset();
        req = 4'b0001;
        step();
        chk("cl_gnt", 32'(gnt), 32'h1);
        serve(0, 10'd700, 10'd512);
        step();
        chk("zlp_gnt", 32'(gnt), 32'h1);
        serve(0, 10'd0, 10'd0);
        req = 4'b0000;
        step();

        // Not ready holds off grant.
        do_reset();
        bif.buf_in_ready = 1'b0;
        req = 4'b0010;
        repeat (6) step();
        chk("nr_gnt", 32'(gnt), 32'd0);
        bif.buf_in_ready = 1'b1;
        step();
        chk("nr_rise_gnt", 32'(gnt), 32'h2);

        // Abort: req drops in FILL, no commit, priority unchanged.
        req = 4'b0000;
        step();
        chk("ab_gnt", 32'(gnt), 32'd0);
        chk("ab_commit", 32'(bif.buf_in_commit), 32'd0);
        step();
        chk("ab_done", 32'(commit_done), 32'd0);
        req = 4'b1111;
        step();
        chk("ab_last_kept", 32'(gnt), 32'h1);

        // Timeout: ack never comes.
        req_done[0] = 1'b1; req_len[9:0] = 10'd5;
        step();
        req_done[0] = 1'b0;
        chk("to_commit", 32'(bif.buf_in_commit), 32'd1);
        repeat (254) step();
        chk("to_commit_hold", 32'(bif.buf_in_commit), 32'd1);
        chk("to_err_early", 32'(commit_err), 32'd0);
        step();
        chk("to_err", 32'(commit_err), 32'd1);
        chk("to_commit_drop", 32'(bif.buf_in_commit), 32'd0);
        chk("to_gnt", 32'(gnt), 32'd0);
        chk("to_no_done", 32'(commit_done), 32'd0);
        step();
        chk("to_err_1cyc", 32'(commit_err), 32'd0);
        chk("to_next_gnt", 32'(gnt), 32'h2);

        // Reset in the middle of a commit.
        req_done[1] = 1'b1; req_len[19:10] = 10'd10;
        step();
        req_done[1] = 1'b0;
        chk("rc_commit", 32'(bif.buf_in_commit), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rc_commit_clr", 32'(bif.buf_in_commit), 32'd0);
        chk("rc_gnt_clr", 32'(gnt), 32'd0);
        chk("rc_len_clr", 32'(bif.buf_in_commit_len), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rc_next_gnt", 32'(gnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/usb2_ep_arb.md
# usb2_ep_arb

Round-robin arbiter and commit sequencer that shares one usb2 endpoint IN-buffer write port (`buf_in_*`) between four local data producers in the `phy_clk` domain. It grants exclusive buffer access to one requester at a time and muxes its write stream onto the endpoint. When the requester finishes, the arbiter drives the endpoint commit handshake (`buf_in_commit` / `buf_in_commit_ack`) and returns a completion pulse. It sits between application-side packet sources and a usb2_ep instance.

## Interface
- `N_REQ`, 4: number of requesters. The logic is written for exactly 4.
- `ACK_TIMEOUT`, 8'd255: `phy_clk` cycles to wait for `buf_in_commit_ack` before aborting a commit.
- `MAX_LEN`, 10'd512: endpoint buffer size in bytes; commit length clamp.

- `phy_clk` in 1: single clock. All logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req` in 4: per-requester access request, level.
- `req_done` in 4: per-requester "buffer written, commit now". Sampled only for the granted requester.
- `req_len` in 40: packed commit lengths. `req_len[10*i+9:10*i]` belongs to requester i.
- `req_addr` in 36: packed write addresses, 9 bits per requester.
- `req_data` in 32: packed write data, 8 bits per requester.
- `req_wren` in 4: per-requester write enable.
- `gnt` out 4: one-hot grant, registered.
- `commit_done` out 4: one-cycle completion pulse to the granted requester.
- `commit_err` out 1: one-cycle pulse on commit timeout.
- `buf_in_addr` out 9: muxed address of the granted requester.
- `buf_in_data` out 8: muxed data of the granted requester.
- `buf_in_wren` out 1: muxed write enable.
- `buf_in_ready` in 1: endpoint current buffer is free.
- `buf_in_commit` out 1: commit request to the endpoint, level, registered.
- `buf_in_commit_len` out 10: commit length, registered.
- `buf_in_commit_ack` in 1: endpoint commit acknowledge, a multi-cycle pulse.

## Operation
- **State machine:** IDLE, FILL, COMMIT, ACKLOW.
- **IDLE**
  - Acts only when `buf_in_ready` is 1 and `req` is nonzero.
  - Picks the first asserted `req[i]`, searching circularly from `last+1` mod 4.
  - Sets `gnt` to the one-hot value for i and moves to FILL.
  - `last` is a 2-bit pointer with reset value 3, so requester 0 wins first.
- **FILL**
  - `buf_in_addr`, `buf_in_data` and `buf_in_wren` are a combinational mux of the granted slices. `buf_in_wren` is `req_wren[g]` gated by being in FILL; it is 0 in every other state.
  - If `req_done[g]` is 1:
    - latch `buf_in_commit_len` = min(`req_len[g]`, `MAX_LEN`); a length of 0 is legal (zero-length packet);
    - assert `buf_in_commit`, clear the timeout counter, move to COMMIT.
  - Else if `req[g]` drops: abort. Clear `gnt`, go to IDLE, and do not update `last`. Bytes already written are abandoned and no commit is issued.
- **COMMIT**
  - Hold `buf_in_commit` high; the counter increments each cycle.
  - On `buf_in_commit_ack` = 1: drop `buf_in_commit` and move to ACKLOW.
  - If the counter reaches `ACK_TIMEOUT`: drop `buf_in_commit`, pulse `commit_err`, clear `gnt`, set `last` = g, go to IDLE.
- **ACKLOW**
  - Wait for `buf_in_commit_ack` = 0; the endpoint has then swapped buffers.
  - Then pulse `commit_done[g]`, clear `gnt`, set `last` = g, go to IDLE.
- **Ignored inputs:** `req_done` and `req_wren` of non-granted requesters have no effect. `req_done[g]` outside FILL has no effect.
- **Reset** (`reset_n` = 0 at a clock edge, from any state, including mid-commit):
  - state IDLE, `gnt` 0, `buf_in_commit` 0, `buf_in_commit_len` 0;
  - `commit_done` 0, `commit_err` 0, counter 0, `last` 3.
  - An endpoint left mid-ack is tolerated: IDLE waits for `buf_in_ready`.

## Timing
- **Grant latency:** `req` sampled high in IDLE with ready at edge k gives `gnt` valid after edge k. The first usable write is at edge k+1.
- **Commit latency:** `req_done` sampled at edge k gives `buf_in_commit` = 1 and a valid length after edge k.
- **Commit hold:** `buf_in_commit` stays high until the first edge that samples ack = 1, which is at least the endpoint's synchronizer depth (3 cycles).
- **Completion:** `commit_done` is high exactly one cycle, the cycle after ack is sampled low. `gnt` falls together with it.
- **Back-to-back:** minimum gap from `commit_done` to the next `gnt` is 1 cycle (the IDLE evaluation).
- **Simultaneous requests:** a requester that was just served has lowest priority on the next arbitration.

## Test plan
- **Single transfer:** `req[0]` with ready = 1; write 3 bytes at addresses 0..2; `req_done[0]` with `req_len[0]` = 3.
  - Requires `gnt` = 0001 one cycle later and `buf_in_wren` pulses on exactly 3 cycles.
  - Requires `buf_in_commit` high until ack, `buf_in_commit_len` = 3, and a single `commit_done[0]` pulse after ack falls.
- **Round-robin:** `req` = 1111 held, each requester commits on grant. Grant order must be 0, 1, 2, 3, 0.
- **Length clamp and ZLP:** `req_len` = 700 gives `buf_in_commit_len` = 512; `req_len` = 0 gives 0, and the commit still completes.
- **Not ready:** ready = 0 with `req` = 0010 keeps `gnt` = 0 indefinitely. Ready rising gives `gnt` = 0010 on the next cycle.
- **Timeout and abort:**
  - Ack tied to 0 gives `commit_err` one pulse at `ACK_TIMEOUT` cycles after commit, then IDLE.
  - `req[g]` dropping in FILL clears `gnt` with no commit and no `commit_done`.
- **Reset mid-COMMIT:** `reset_n` = 0 for 1 cycle makes `buf_in_commit` = 0 and `gnt` = 0 on the next cycle, and the next grant goes to requester 0.
